// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, opcodes and the data-memory responder state type
package cpu_pkg;
  localparam int WORD_W = 19;
  localparam int ADDR_W = 19;
  localparam int DMEM_DEPTH = 1024;
  localparam logic [4:0] OP_LD = 5'b01111;
  localparam logic [4:0] OP_ST = 5'b10000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
endpackage

// File: rtl/cpu_dmem_responder_if.sv
// cpu_dmem_responder_if: LD/ST request and response channels between core and data memory
interface cpu_dmem_responder_if #(
  parameter int WORD_W = cpu_pkg::WORD_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_sp_ram.sv
// dmem_sp_ram: single-port synchronous RAM with registered read data
module dmem_sp_ram #(
  parameter int WORD_W = 19,
  parameter int DEPTH = 1024
) (
  input logic clk,
  input logic en,
  input logic we,
  input logic [$clog2(DEPTH)-1:0] addr,
  input logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  // one access per enabled edge; read data only updates on enabled loads
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/cpu_dmem_responder.sv
// cpu_dmem_responder: data-memory target with programmable wait states, range check and error count
module cpu_dmem_responder #(
  parameter int WORD_W = cpu_pkg::WORD_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH = cpu_pkg::DMEM_DEPTH,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  cpu_dmem_responder_if.slave bus,
  output logic [7:0] err_count
);
  import cpu_pkg::*;
  localparam int AW = $clog2(DEPTH);
  dmem_state_e state, state_n;
  logic [3:0] cnt;
  logic we_q, rd_ok, err_q, access, in_range, cur_we, accept;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic [WORD_W-1:0] wdata_q, cur_wdata, ram_rdata;
  // zero-wait builds access memory on the accept edge straight from the bus
  always_comb begin
    accept = state == IDLE && bus.req_valid;
    cur_we = state == IDLE ? bus.req_we : we_q;
    cur_addr = state == IDLE ? bus.req_addr : addr_q;
    cur_wdata = state == IDLE ? bus.req_wdata : wdata_q;
    in_range = cur_addr < ADDR_W'(DEPTH);
    access = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
    state_n = state == IDLE ? (bus.req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) :
              (bus.rsp_ready ? IDLE : RESP);
  end
  // state, wait counter, captured request and response flags
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_ok <= 1'b0;
      err_q <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q <= bus.req_we;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (access) begin
        rd_ok <= !cur_we && in_range;
        err_q <= !in_range;
        if (!in_range && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (state == RESP && bus.rsp_ready) err_q <= 1'b0;
    end
  dmem_sp_ram #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk),
    .en(access && in_range),
    .we(cur_we),
    .addr(cur_addr[AW-1:0]),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rd_ok ? ram_rdata : '0;
  assign bus.rsp_err = err_q;
endmodule

// File: tb/tb_cpu_dmem_responder.sv
// tb_cpu_dmem_responder: directed scoreboard bench for a 2-wait and a 0-wait responder
module tb_cpu_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] ec2, ec0;
  int vecs = 0;
  int miss = 0;
  logic [19:0] sb[$];
  cpu_dmem_responder_if #(.WORD_W(19), .ADDR_W(19)) b2();
  cpu_dmem_responder_if #(.WORD_W(19), .ADDR_W(19)) b0();
  cpu_dmem_responder #(.WAIT_CYCLES(2)) u2 (.clk(clk), .reset(reset), .bus(b2), .err_count(ec2));
  cpu_dmem_responder #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(b0), .err_count(ec0));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic txn2(input logic we, input logic [18:0] addr, input logic [18:0] wdata,
                      input logic [18:0] exp_rd, input logic exp_err, input int hold);
    logic [19:0] e;
    int cyc;
    sb.push_back({exp_err, exp_rd});
    @(negedge clk);
    chk("req_ready_idle", b2.req_ready, 1);
    b2.req_valid = 1'b1;
    b2.req_we = we;
    b2.req_addr = addr;
    b2.req_wdata = wdata;
    b2.rsp_ready = hold == 0;
    @(negedge clk);
    b2.req_we = ~we;
    b2.req_addr = 19'h00003;
    b2.req_wdata = 19'h7FFFF;
    cyc = 1;
    while (!b2.rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    b2.req_valid = 1'b0;
    chk("latency", cyc, 3);
    e = sb.pop_front();
    chk("rdata", b2.rsp_rdata, e[18:0]);
    chk("err", b2.rsp_err, e[19]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", b2.rsp_valid, 1);
      chk("hold_rdata", b2.rsp_rdata, e[18:0]);
      chk("hold_err", b2.rsp_err, e[19]);
      chk("hold_req_ready", b2.req_ready, 0);
    end
    b2.rsp_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", b2.rsp_valid, 0);
    chk("err_drop", b2.rsp_err, 0);
    chk("req_ready_back", b2.req_ready, 1);
  endtask
  initial begin
    logic [19:0] e;
    logic [18:0] d;
    b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = '0; b2.req_wdata = '0; b2.rsp_ready = 1'b1;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", b2.req_ready, 1);
    chk("rst_rsp_valid", b2.rsp_valid, 0);
    chk("rst_rdata", b2.rsp_rdata, 0);
    chk("rst_err", b2.rsp_err, 0);
    chk("rst_err_count", ec2, 0);
    txn2(1'b1, 19'd5, 19'h01234, 19'h0, 1'b0, 0);
    txn2(1'b0, 19'd5, 19'h0, 19'h01234, 1'b0, 0);
    txn2(1'b1, 19'd1023, 19'h5A5A5, 19'h0, 1'b0, 0);
    txn2(1'b0, 19'd1024, 19'h0, 19'h0, 1'b1, 0);
    chk("err_count_1", ec2, 1);
    txn2(1'b1, 19'h7FFFF, 19'h000AA, 19'h0, 1'b1, 0);
    chk("err_count_2", ec2, 2);
    txn2(1'b0, 19'd1023, 19'h0, 19'h5A5A5, 1'b0, 0);
    txn2(1'b0, 19'd1029, 19'h0, 19'h0, 1'b1, 0);
    chk("err_count_3", ec2, 3);
    txn2(1'b0, 19'd5, 19'h0, 19'h01234, 1'b0, 5);
    txn2(1'b1, 19'd7, 19'h00ABC, 19'h0, 1'b0, 0);
    @(negedge clk);
    b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_addr = 19'd7; b2.req_wdata = 19'h3FFFF;
    @(negedge clk);
    b2.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_req_ready", b2.req_ready, 1);
    chk("mid_rsp_valid", b2.rsp_valid, 0);
    chk("mid_rdata", b2.rsp_rdata, 0);
    chk("mid_err", b2.rsp_err, 0);
    chk("mid_err_count", ec2, 0);
    repeat (4) @(negedge clk);
    chk("mid_still_idle", b2.rsp_valid, 0);
    txn2(1'b0, 19'd7, 19'h0, 19'h00ABC, 1'b0, 0);
    @(negedge clk);
    b0.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 19'(32'h2A000 + (i % 3) * 32'h135);
      chk("z_req_ready", b0.req_ready, 1);
      b0.req_we = i < 3;
      b0.req_addr = 19'(i % 3);
      b0.req_wdata = i < 3 ? d : 19'h7FFFF;
      sb.push_back({1'b0, i < 3 ? 19'h0 : d});
      @(negedge clk);
      e = sb.pop_front();
      chk("z_rsp_valid", b0.rsp_valid, 1);
      chk("z_busy", b0.req_ready, 0);
      chk("z_rdata", b0.rsp_rdata, e[18:0]);
      chk("z_err", b0.rsp_err, e[19]);
      @(negedge clk);
    end
    b0.req_we = 1'b0;
    for (int i = 0; i < 300; i++) begin
      b0.req_addr = 19'(32'h400 + i * 32'd97);
      @(negedge clk);
      chk("sat_err", b0.rsp_err, 1);
      chk("sat_count", ec0, i < 255 ? i + 1 : 255);
      @(negedge clk);
    end
    b0.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sat_final", ec0, 255);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/cpu_dmem_responder.md
Name: cpu_dmem_responder

Overview:
- Data-memory responder for the 19-bit CPU core: the target end of the core's LD/ST data-memory interface.
- Accepts one load or store request at a time over a valid/ready request channel and inserts a programmable number of wait states.
- Returns read data or a write acknowledgement over a valid/ready response channel.
- Flags out-of-range addresses, counts them, and replaces the core's direct array access so memory timing can be modelled.

Parameters:
- WORD_W, 19, data word width (matches the CPU register width).
- ADDR_W, 19, request address width (the full register width, since the core addresses memory with a register value).
- DEPTH, 1024, number of words implemented; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states between request acceptance and the memory access; 0..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store (ST), 0 = load (LD).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  WORD_W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  WORD_W  load data; 0 for stores and for errors.
- rsp_err  out  1  address was >= DEPTH.
- err_count  out  8  saturating count of errored requests.

Behaviour:
- Reset (synchronous):
  - state = IDLE; req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_count = 0, wait counter = 0.
  - Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid at edge T, capture we/addr/wdata and set the wait counter to WAIT_CYCLES.
  - If WAIT_CYCLES = 0, perform the access at edge T and go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - req_ready = 0; the counter decrements each cycle.
  - When the counter reaches 1, perform the access at that edge and go to RESP.
  - Access edge = T + WAIT_CYCLES.
  - rsp_valid rises in the cycle after the access edge, i.e. latency = WAIT_CYCLES + 1 cycles from the accept edge.
- Access rules:
  - Range check: addr < DEPTH is in range.
  - Load in range: rsp_rdata = mem[addr].
  - Store in range: mem[addr] = wdata; rsp_rdata = 0.
  - Out of range: no memory write; rsp_rdata = 0; rsp_err = 1; err_count increments, saturating at 255.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable while rsp_ready = 0.
  - On rsp_ready, clear rsp_valid and rsp_err (rsp_rdata may hold) and go to IDLE.
  - req_ready is asserted in the following cycle; there is no request/response overlap.
  - Minimum period per transaction = WAIT_CYCLES + 2 cycles.
- Request channel: req_* inputs are ignored whenever req_ready = 0; only the accept-edge values are used.
- Reset mid-operation:
  - Reset in WAIT aborts the pending transaction; a pending store is NOT committed.
  - Reset in RESP drops the response.
  - Reset has priority over every other event in the same cycle.
- Read-after-write: a load issued after a store's response has been accepted returns the new data.
- All arithmetic is unsigned. The address comparison uses the full ADDR_W bits; there is no truncation or wrap of high bits.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W = 19 and DMEM_DEPTH = 1024;
  - the responder state enum (IDLE, WAIT, RESP);
  - opcode constants OP_LD = 5'b01111 and OP_ST = 5'b10000, shared with the core's decoder.
- One sub-module, dmem_sp_ram: single-port synchronous RAM, DEPTH x WORD_W, with we, addr, wdata and registered rdata.
- The responder FSM, wait counter, range check and error counter live in cpu_dmem_responder.

Test Plan:
1. Store then load, WAIT_CYCLES = 2:
   - ST addr 5, data 19'h1234 accepted at edge T -> rsp_valid at T+3 with rdata 0 and err 0.
   - LD addr 5 -> rdata 19'h1234 with err 0.
2. Out of range:
   - LD addr 1024 -> rsp_err = 1, rdata 0, err_count = 1.
   - ST addr 19'h7FFFF, data 19'h00AA -> err_count = 2; a subsequent LD of addr 1023 returns its prior value unchanged.
3. Backpressure:
   - Hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_valid, rdata and err stable throughout; req_ready = 0.
   - Release -> rsp_valid drops next cycle; req_ready = 1 the cycle after.
4. Reset mid-WAIT:
   - ST addr 7, data 19'h3FFFF, reset asserted one cycle after accept -> all outputs return to reset values.
   - LD addr 7 returns the pre-store value.
5. WAIT_CYCLES = 0 build with back-to-back requests and rsp_ready tied to 1:
   - Responses arrive 1 cycle after accept; throughput is one transaction per 2 cycles.
   - Loads of addresses 0, 1, 2 return the data previously stored there.
6. Error saturation: 300 out-of-range requests -> err_count = 255, never wraps to 0.
